pulse_rate_bcd: RTL

PULSE_RATE_BCD -- requirements
Module: pulse_rate_bcd

---
 rtl/pulse_rate_bcd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_rate_bcd.sv
// pulse_rate_bcd
// Counts debounced rising edges of an asynchronous sensor pulse over a fixed
// gate window and presents the result as two saturating BCD digits with an
// overflow flag. The display outputs update once per window, and VALID strobes
// on the following cycle.

module pulse_rate_bcd #(
    parameter int GATE_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PULSE,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       OVERFLOW,
    output logic       VALID
);

    // Gate counter width covers 0..GATE_CYCLES-1.
    localparam int              GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Debounce counter reaches DB_LAST on the final differing sample.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic pulse_meta;
    logic pulse_sync;

    // Two-flop synchronizer for the asynchronous sensor input.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge; blocking here would collapse the chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pulse_meta <= 1'b0;
            pulse_sync <= 1'b0;
        end else begin
            pulse_meta <= PULSE;
            pulse_sync <= pulse_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [7:0] db_cnt;
    logic       level;

    // Accept a new level only after it has persisted for DEBOUNCE_CYCLES samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_cnt <= 8'd0;
            level  <= 1'b0;
        end else if (pulse_sync == level) begin
            db_cnt <= 8'd0;
        end else if (db_cnt == DB_LAST) begin
            level  <= pulse_sync;
            db_cnt <= 8'd0;
        end else begin
            db_cnt <= db_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Rising-edge detect on the accepted level
    // ------------------------------------------------------------------
    logic level_d;
    logic rise;

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // One-cycle strobe on each 0->1 change of the accepted level.
    assign rise = level & ~level_d;

    // ------------------------------------------------------------------
    // Gate (window) counter
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt;
    logic              window_close;

    // Free-running window counter, wrapping after GATE_CYCLES cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gate_cnt <= '0;
        end else if (gate_cnt == GATE_LAST) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // The last cycle of the window is the one that publishes the count.
    assign window_close = (gate_cnt == GATE_LAST);

    // ------------------------------------------------------------------
    // BCD accumulator
    // ------------------------------------------------------------------
    logic [3:0] acc_u;
    logic [3:0] acc_t;
    logic       acc_ovf;
    logic [3:0] nxt_u;
    logic [3:0] nxt_t;
    logic       nxt_ovf;

    // Saturating BCD increment; the window-close latch uses this value so an
    // edge on the closing cycle is included.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        nxt_u   = acc_u;
        nxt_t   = acc_t;
        nxt_ovf = acc_ovf;
        if (rise) begin
            if (acc_u == 4'd9 && acc_t == 4'd9) begin
                nxt_ovf = 1'b1;
            end else if (acc_u == 4'd9) begin
                nxt_u = 4'd0;
                nxt_t = acc_t + 4'd1;
            end else begin
                nxt_u = acc_u + 4'd1;
            end
        end
    end

    // Accumulate within the window; restart from zero after each close.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_u   <= 4'd0;
            acc_t   <= 4'd0;
            acc_ovf <= 1'b0;
        end else if (window_close) begin
            acc_u   <= 4'd0;
            acc_t   <= 4'd0;
            acc_ovf <= 1'b0;
        end else begin
            acc_u   <= nxt_u;
            acc_t   <= nxt_t;
            acc_ovf <= nxt_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Published result and VALID strobe
    // ------------------------------------------------------------------
    logic close_d;

    // Display registers change only at window close, so they never show
    // a partial count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            units    <= 4'd0;
            tens     <= 4'd0;
            OVERFLOW <= 1'b0;
        end else if (window_close) begin
            units    <= nxt_u;
            tens     <= nxt_t;
            OVERFLOW <= nxt_ovf;
        end
    end

    // VALID rises on the cycle after the display registers update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            close_d <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            close_d <= window_close;
            VALID   <= close_d;
        end
    end

endmodule
